// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - loadable instruction memory with wait-stated req/ready/valid fetch port
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   ld_valid/addr/data/last  word-write load port, honoured only while loading
//   ld_count, loaded         words written since reset (saturating), load finished
//   fetch_req/pc/ready       fetch request handshake (accepted on req & ready & !flush)
//   flush                    abort the in-flight fetch
//   inst_valid/inst/fault    one-cycle result pulse; inst/inst_fault hold between pulses
module imem_fetch_ctrl #(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 128,
    parameter int                WAIT_STATES = 0,
    parameter int                BYTE_ADDR   = 1,
    parameter logic [DATA_W-1:0] NOP         = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       ld_last,
    output logic [$clog2(DEPTH+1)-1:0] ld_count,
    output logic                       loaded,
    input  logic                       fetch_req,
    input  logic [31:0]                fetch_pc,
    output logic                       fetch_ready,
    input  logic                       flush,
    output logic                       inst_valid,
    output logic [DATA_W-1:0]          inst,
    output logic                       inst_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [3:0]        wcnt;
    logic [DATA_W-1:0] mem [DEPTH];

    // Result being presented this RESP cycle, and the last result actually delivered.
    logic [DATA_W-1:0] pend_data;
    logic              pend_fault;
    logic [DATA_W-1:0] out_data;
    logic              out_fault;

    logic [31:0]       idx_c;
    logic              fault_c;
    logic [DATA_W-1:0] rd_data;
    logic              ld_in_range;
    logic              accept;

    always_comb begin
        idx_c       = (BYTE_ADDR != 0) ? {2'b00, fetch_pc[31:2]} : fetch_pc;
        fault_c     = ((BYTE_ADDR != 0) && (fetch_pc[1:0] != 2'b00)) || (idx_c >= 32'(DEPTH));
        rd_data     = mem[idx_c[AW-1:0]];
        ld_in_range = (32'(ld_addr) < 32'(DEPTH));
    end

    assign fetch_ready = (state == S_IDLE) || (state == S_RESP);
    // flush outranks a request in the same cycle
    assign accept      = fetch_req && fetch_ready && !flush;
    // flush in RESP suppresses the pulse; inst then keeps showing the previous result
    assign inst_valid  = (state == S_RESP) && !flush;
    assign inst        = inst_valid ? pend_data  : out_data;
    assign inst_fault  = inst_valid ? pend_fault : out_fault;

    // Contents survive reset so a program can be re-run without reloading.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && ld_valid && ld_in_range && !rst) begin
            mem[ld_addr[AW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LOAD;
            wcnt       <= '0;
            ld_count   <= '0;
            loaded     <= 1'b0;
            pend_data  <= NOP;
            pend_fault <= 1'b0;
            out_data   <= NOP;
            out_fault  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (ld_valid) begin
                        if (ld_in_range && ld_count != CW'(DEPTH)) begin
                            ld_count <= ld_count + 1'b1;
                        end
                        if (ld_last) begin
                            state  <= S_IDLE;
                            loaded <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        pend_data  <= fault_c ? NOP : rd_data;
                        pend_fault <= fault_c;
                        wcnt       <= 4'(WAIT_STATES);
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // WAIT always lasts WAIT_STATES+1 cycles: one access cycle plus the
                    // extra wait states, giving the documented N+1+WAIT_STATES latency.
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (wcnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        out_data  <= pend_data;
                        out_fault <= pend_fault;
                        if (accept) begin
                            pend_data  <= fault_c ? NOP : rd_data;
                            pend_fault <= fault_c;
                            wcnt       <= 4'(WAIT_STATES);
                            state      <= S_WAIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    localparam int DW = 32;
    localparam int WS = 2;
    localparam logic [31:0] NOPW = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [6:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic [7:0]  ld_count;
    logic        loaded;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_fault;

    imem_fetch_ctrl #(.DATA_W(DW), .DEPTH(128), .WAIT_STATES(WS), .BYTE_ADDR(1), .NOP(NOPW)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .ld_count(ld_count), .loaded(loaded),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .flush(flush),
        .inst_valid(inst_valid), .inst(inst), .inst_fault(inst_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          at;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per inst_valid pulse, checks data, fault and arrival cycle.
    always @(negedge clk) begin
        if (inst_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_inst_valid", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("inst", inst, e.data);
                check("inst_fault", 32'(inst_fault), 32'(e.fault));
                check("inst_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic load_word(input logic [6:0] a, input logic [31:0] d, input logic last);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    // Drive a request until accepted; optionally record the expected result.
    task automatic issue(input logic [31:0] pc, input logic hold, input logic want,
                         input logic [31:0] ed, input logic ef, input logic with_flush);
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            fetch_req = 1'b1;
            fetch_pc  = pc;
            if (fetch_ready === 1'b1) begin
                @(negedge clk);
                done = 1;
                if (want) begin
                    exp_t e;
                    e.data = ed; e.fault = ef; e.at = cyc + 1 + WS;
                    sb.push_back(e);
                end
                if (!hold) fetch_req = 1'b0;
                if (with_flush) flush = 1'b0;
            end
        end
        if (!done) begin
            fetch_req = 1'b0;
            check("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ld_valid = 0; ld_addr = 0; ld_data = 0; ld_last = 0;
        fetch_req = 0; fetch_pc = 0; flush = 0;
        idle_cycles(3);
        check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, NOPW);
        check("rst_inst_fault", 32'(inst_fault), 32'd0);
        check("rst_ld_count", 32'(ld_count), 32'd0);
        check("rst_loaded", 32'(loaded), 32'd0);
        rst = 1'b0;

        // 1. load four words
        load_word(7'd0, 32'hA0, 1'b0);
        load_word(7'd1, 32'hA1, 1'b0);
        load_word(7'd2, 32'hA2, 1'b0);
        check("loaded_before_last", 32'(loaded), 32'd0);
        check("ready_in_load", 32'(fetch_ready), 32'd0);
        load_word(7'd3, 32'hA3, 1'b1);
        check("ld_count_4", 32'(ld_count), 32'd4);
        check("loaded_1", 32'(loaded), 32'd1);
        check("ready_after_load", 32'(fetch_ready), 32'd1);

        // 2. aligned fetch with latency check in the monitor
        issue(32'd8, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b0);
        idle_cycles(6);

        // 3. faults and ignored loads after LOAD
        issue(32'd6, 1'b0, 1'b1, NOPW, 1'b1, 1'b0);
        idle_cycles(6);
        issue(32'd512, 1'b0, 1'b1, NOPW, 1'b1, 1'b0);
        idle_cycles(6);
        check("held_inst_fault", 32'(inst_fault), 32'd1);
        load_word(7'd2, 32'hFF, 1'b0);
        check("ld_count_ignored", 32'(ld_count), 32'd4);
        issue(32'd8, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b0);
        idle_cycles(6);
        check("held_inst", inst, 32'hA2);

        // 4. flush during WAIT, then flush+req in IDLE
        issue(32'd4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("ready_after_flush", 32'(fetch_ready), 32'd1);
        idle_cycles(6);
        flush = 1'b1; fetch_req = 1'b1; fetch_pc = 32'd4;
        @(negedge clk);
        flush = 1'b0; fetch_req = 1'b0;
        check("flush_blocks_req", 32'(fetch_ready), 32'd1);
        idle_cycles(6);

        // 5. back-to-back with fetch_req held
        issue(32'd0, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b0);
        fetch_pc = 32'd4;
        issue(32'd4, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b0);
        idle_cycles(8);

        // 6. reset mid-fetch, reload one word, memory retained
        issue(32'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_loaded", 32'(loaded), 32'd0);
        check("rst2_ready", 32'(fetch_ready), 32'd0);
        idle_cycles(5);
        load_word(7'd5, 32'hB5, 1'b1);
        check("rst2_ld_count", 32'(ld_count), 32'd1);
        check("rst2_loaded_1", 32'(loaded), 32'd1);
        issue(32'd0, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b0);
        idle_cycles(8);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
